// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller driving a combinational ALU.
// Accepts one MIPS instruction, reads rs/rt from a synchronous-read register
// file, holds the ALU inputs for SETTLE_CYCLES (1..15), then writes back,
// resolves a branch or flags an illegal encoding.
// Optional feature macro: ALU_SEQ_PERF_EN (retired/illegal perf counters).
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int RF_ADDR_W     = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [31:0]          instr,
    output logic [RF_ADDR_W-1:0] rf_rs_addr,
    output logic [RF_ADDR_W-1:0] rf_rt_addr,
    input  logic [31:0]          rf_rs_data,
    input  logic [31:0]          rf_rt_data,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic [5:0]           alu_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    input  logic [31:0]          alu_result,
    input  logic                 alu_condition,
    output logic                 done,
    output logic                 branch_valid,
    output logic                 branch_taken,
    output logic                 illegal,
    output logic [31:0]          perf_retired,
    output logic [15:0]          perf_illegal
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} ctrlState;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] ALU_NOP     = 6'b111111;

    ctrlState state;

    // Only the instruction fields needed after READ are kept.
    logic [5:0]  opQ;
    logic [4:0]  rtQ;
    logic [15:0] immQ;

    // First EXEC cycle loads the ALU inputs (register data is valid then);
    // settleCnt then counts the cycles the inputs are held.
    logic        opsLoaded;
    logic [3:0]  settleCnt;
    logic        retireNow;

    // Decode results captured alongside the ALU inputs for write-back.
    logic                 wbWrite;
    logic [RF_ADDR_W-1:0] wbAddr;
    logic                 wbBranch;
    logic                 wbInvert;
    logic                 wbSetLess;
    logic                 wbIllegal;

    logic [5:0]           funct;
    logic [31:0]          immSext;
    logic [31:0]          immZext;
    logic                 rTypeLegal;
    logic [5:0]           decOp;
    logic [31:0]          decA;
    logic [31:0]          decB;
    logic [RF_ADDR_W-1:0] decWaddr;
    logic                 decWrite;
    logic                 decBranch;
    logic                 decInvert;
    logic                 decSetLess;
    logic                 decIllegal;

    assign funct     = immQ[5:0];
    assign immSext   = {{16{immQ[15]}}, immQ};
    assign immZext   = {16'h0000, immQ};
    assign retireNow = (state == EXEC) && opsLoaded && (settleCnt == 4'd1);

    // Supported SPECIAL funct codes pass straight through as the ALU op.
    always_comb begin
        case (funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011, 6'b000000, 6'b000010,
            6'b000011, 6'b000100, 6'b000110, 6'b000111,
            6'b001010, 6'b001011: rTypeLegal = 1'b1;
            default:              rTypeLegal = 1'b0;
        endcase
    end

    // Instruction decode into ALU inputs and write-back/branch intent.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        decOp      = ALU_NOP;
        decA       = 32'h0;
        decB       = 32'h0;
        decWaddr   = '0;
        decWrite   = 1'b0;
        decBranch  = 1'b0;
        decInvert  = 1'b0;
        decSetLess = 1'b0;
        decIllegal = 1'b0;
        case (opQ)
            OP_SPECIAL: begin
                if (rTypeLegal) begin
                    decOp      = funct;
                    decA       = rf_rs_data;
                    decB       = rf_rt_data;
                    decWaddr   = RF_ADDR_W'(immQ[15:11]);
                    decSetLess = (funct == 6'b101010) || (funct == 6'b101011);
                    case (funct)
                        6'b001010: decWrite = (rf_rt_data == 32'h0);  // MOVZ
                        6'b001011: decWrite = (rf_rt_data != 32'h0);  // MOVN
                        default:   decWrite = 1'b1;
                    endcase
                end else begin
                    decIllegal = 1'b1;
                end
            end
            OP_SPECIAL2: begin
                if (funct == 6'b100001 || funct == 6'b100000) begin
                    decOp    = funct[0] ? 6'b011100 : 6'b011101;  // CLO : CLZ
                    decA     = rf_rs_data;
                    decWaddr = RF_ADDR_W'(immQ[15:11]);
                    decWrite = 1'b1;
                end else begin
                    decIllegal = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: begin
                decA     = rf_rs_data;
                decWaddr = RF_ADDR_W'(rtQ);
                decWrite = 1'b1;
                case (opQ)
                    OP_ADDI:  begin decOp = 6'b100000; decB = immSext; end
                    OP_ADDIU: begin decOp = 6'b100001; decB = immSext; end
                    OP_SLTI:  begin decOp = 6'b101010; decB = immSext; decSetLess = 1'b1; end
                    OP_SLTIU: begin decOp = 6'b101011; decB = immSext; decSetLess = 1'b1; end
                    OP_ANDI:  begin decOp = 6'b100100; decB = immZext; end
                    OP_ORI:   begin decOp = 6'b100101; decB = immZext; end
                    default:  begin decOp = 6'b100110; decB = immZext; end  // XORI
                endcase
            end
            OP_LUI: begin
                decOp    = ALU_NOP;
                decA     = {immQ, 16'h0000};
                decWaddr = RF_ADDR_W'(rtQ);
                decWrite = 1'b1;
            end
            OP_J: begin
                decOp     = 6'b011111;
                decBranch = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                // Equality is tested as "rs ^ rt is zero" by the ALU.
                decOp     = 6'b011011;
                decA      = rf_rs_data ^ rf_rt_data;
                decBranch = 1'b1;
                decInvert = (opQ == OP_BNE);
            end
            OP_BLEZ: begin
                decOp     = 6'b010011;
                decA      = rf_rs_data;
                decBranch = 1'b1;
            end
            OP_BGTZ: begin
                decOp     = 6'b001101;
                decA      = rf_rs_data;
                decBranch = 1'b1;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // Issue FSM: accept, read, hold ALU inputs, retire; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            opQ          <= '0;
            rtQ          <= '0;
            immQ         <= '0;
            opsLoaded    <= 1'b0;
            settleCnt    <= '0;
            wbWrite      <= 1'b0;
            wbAddr       <= '0;
            wbBranch     <= 1'b0;
            wbInvert     <= 1'b0;
            wbSetLess    <= 1'b0;
            wbIllegal    <= 1'b0;
            rf_rs_addr   <= '0;
            rf_rt_addr   <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= 32'h0;
            alu_op       <= '0;
            alu_a        <= 32'h0;
            alu_b        <= 32'h0;
            done         <= 1'b0;
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples pre-edge values regardless of statement order.
            done         <= 1'b0;
            rf_we        <= 1'b0;
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        opQ         <= instr[31:26];
                        rtQ         <= instr[20:16];
                        immQ        <= instr[15:0];
                        rf_rs_addr  <= RF_ADDR_W'(instr[25:21]);
                        rf_rt_addr  <= RF_ADDR_W'(instr[20:16]);
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    opsLoaded <= 1'b0;
                    settleCnt <= 4'(SETTLE_CYCLES);
                    state     <= EXEC;
                end
                EXEC: begin
                    if (!opsLoaded) begin
                        alu_op    <= decOp;
                        alu_a     <= decA;
                        alu_b     <= decB;
                        wbWrite   <= decWrite && (decWaddr != '0);
                        wbAddr    <= decWaddr;
                        wbBranch  <= decBranch;
                        wbInvert  <= decInvert;
                        wbSetLess <= decSetLess;
                        wbIllegal <= decIllegal;
                        opsLoaded <= 1'b1;
                    end else if (retireNow) begin
                        done         <= 1'b1;
                        rf_we        <= wbWrite;
                        rf_waddr     <= wbAddr;
                        // The ALU set-less ops report a >= b, so invert bit 0.
                        rf_wdata     <= wbSetLess ? {31'h0, ~alu_result[0]} : alu_result;
                        branch_valid <= wbBranch;
                        branch_taken <= wbBranch && (alu_condition ^ wbInvert);
                        illegal      <= wbIllegal;
                        state        <= WB;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                default: begin  // WB
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Perf counters update on the edge that raises done; illegal saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_retired <= 32'h0;
            perf_illegal <= 16'h0;
        end else if (retireNow) begin
            perf_retired <= perf_retired + 32'd1;
            if (wbIllegal && (perf_illegal != 16'hFFFF)) begin
                perf_illegal <= perf_illegal + 16'd1;
            end
        end
    end
`else
    assign perf_retired = 32'h0;
    assign perf_illegal = 16'h0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: scoreboard of predicted retirements,
// a synchronous-read register file model and a bench-driven ALU response.
// A second instance with SETTLE_CYCLES = 3 checks the longer latency.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        bv;
        logic        bt;
        logic        ill;
        int          accept;
    } expT;

    logic        clk = 1'b0;
    logic        reset;
    logic        instrValid, slowValid;
    logic [31:0] instr;
    logic [31:0] aluResult;
    logic        aluCondition;

    logic        instrReady, rfWe, done, branchValid, branchTaken, illegalOut;
    logic [4:0]  rsAddr, rtAddr, rfWaddr;
    logic [31:0] rsData, rtData, rfWdata, aluA, aluB, perfRetired;
    logic [5:0]  aluOp;
    logic [15:0] perfIllegal;

    logic        slReady, slWe, slDone, slBv, slBt, slIll;
    logic [4:0]  slRsAddr, slRtAddr, slWaddr;
    logic [31:0] slRsData, slRtData, slWdata, slA, slB, slPerfRetired;
    logic [5:0]  slOp;
    logic [15:0] slPerfIllegal;

    logic [31:0] rfMem [32];
    expT         sb [$];
    int          checks = 0;
    int          fails = 0;
    int          cycleCnt = 0;
    int          issued = 0;
    int          illegalIssued = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Register file model: data appears the cycle after the address.
    always @(posedge clk) begin
        rsData   <= rfMem[rsAddr];
        rtData   <= rfMem[rtAddr];
        slRsData <= rfMem[slRsAddr];
        slRtData <= rfMem[slRtAddr];
    end

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .RF_ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instrValid), .instr_ready(instrReady), .instr(instr),
        .rf_rs_addr(rsAddr), .rf_rt_addr(rtAddr),
        .rf_rs_data(rsData), .rf_rt_data(rtData),
        .rf_we(rfWe), .rf_waddr(rfWaddr), .rf_wdata(rfWdata),
        .alu_op(aluOp), .alu_a(aluA), .alu_b(aluB),
        .alu_result(aluResult), .alu_condition(aluCondition),
        .done(done), .branch_valid(branchValid), .branch_taken(branchTaken),
        .illegal(illegalOut), .perf_retired(perfRetired), .perf_illegal(perfIllegal)
    );

    alu_issue_ctrl #(.SETTLE_CYCLES(3), .RF_ADDR_W(5)) dutSlow (
        .clk(clk), .reset(reset),
        .instr_valid(slowValid), .instr_ready(slReady), .instr(instr),
        .rf_rs_addr(slRsAddr), .rf_rt_addr(slRtAddr),
        .rf_rs_data(slRsData), .rf_rt_data(slRtData),
        .rf_we(slWe), .rf_waddr(slWaddr), .rf_wdata(slWdata),
        .alu_op(slOp), .alu_a(slA), .alu_b(slB),
        .alu_result(aluResult), .alu_condition(aluCondition),
        .done(slDone), .branch_valid(slBv), .branch_taken(slBt),
        .illegal(slIll), .perf_retired(slPerfRetired), .perf_illegal(slPerfIllegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, expected);
        end
    endtask

    // Reference decode written from the instruction-set description.
    function automatic expT predict(input logic [31:0] iw, input logic [31:0] rsV,
                                    input logic [31:0] rtV, input logic [31:0] res,
                                    input logic cond);
        expT         e;
        logic [5:0]  opc, fn;
        logic [15:0] imm;
        logic        wr;
        logic [4:0]  wa;
        e   = '{default: '0};
        opc = iw[31:26];
        fn  = iw[5:0];
        imm = iw[15:0];
        wr  = 1'b0;
        wa  = 5'd0;
        e.op = 6'b111111;
        case (opc)
            6'b000000:
                if (fn inside {[6'b100000:6'b100111], 6'b101010, 6'b101011, 6'b000000,
                               6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                               6'b001010, 6'b001011}) begin
                    e.op = fn; e.a = rsV; e.b = rtV; wa = iw[15:11];
                    wr = (fn == 6'b001010) ? (rtV == 0) : (fn == 6'b001011) ? (rtV != 0) : 1'b1;
                end else e.ill = 1'b1;
            6'b011100:
                if (fn == 6'b100001) begin e.op = 6'b011100; e.a = rsV; wa = iw[15:11]; wr = 1'b1; end
                else if (fn == 6'b100000) begin e.op = 6'b011101; e.a = rsV; wa = iw[15:11]; wr = 1'b1; end
                else e.ill = 1'b1;
            6'b001000: begin e.op = 6'b100000; e.a = rsV; e.b = {{16{imm[15]}}, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001001: begin e.op = 6'b100001; e.a = rsV; e.b = {{16{imm[15]}}, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001010: begin e.op = 6'b101010; e.a = rsV; e.b = {{16{imm[15]}}, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001011: begin e.op = 6'b101011; e.a = rsV; e.b = {{16{imm[15]}}, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001100: begin e.op = 6'b100100; e.a = rsV; e.b = {16'h0, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001101: begin e.op = 6'b100101; e.a = rsV; e.b = {16'h0, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001110: begin e.op = 6'b100110; e.a = rsV; e.b = {16'h0, imm}; wa = iw[20:16]; wr = 1'b1; end
            6'b001111: begin e.op = 6'b111111; e.a = {imm, 16'h0}; wa = iw[20:16]; wr = 1'b1; end
            6'b000010: begin e.op = 6'b011111; e.bv = 1'b1; e.bt = cond; end
            6'b000100: begin e.op = 6'b011011; e.a = rsV ^ rtV; e.bv = 1'b1; e.bt = cond; end
            6'b000101: begin e.op = 6'b011011; e.a = rsV ^ rtV; e.bv = 1'b1; e.bt = ~cond; end
            6'b000110: begin e.op = 6'b010011; e.a = rsV; e.bv = 1'b1; e.bt = cond; end
            6'b000111: begin e.op = 6'b001101; e.a = rsV; e.bv = 1'b1; e.bt = cond; end
            default:   e.ill = 1'b1;
        endcase
        e.we    = wr && (wa != 5'd0);
        e.waddr = wa;
        e.wdata = (e.op == 6'b101010 || e.op == 6'b101011) ? {31'h0, ~res[0]} : res;
        return e;
    endfunction

    // Scoreboard monitor: compares each retirement against the oldest prediction.
    always @(negedge clk) begin
        expT e;
        if (!reset) begin
            if (rfWe || branchValid || illegalOut) check("strobe_needs_done", 32'(done), 32'd1);
            if (rfWe) check("we_to_r0", 32'(rfWaddr == 5'd0), 32'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("alu_op", 32'(aluOp), 32'(e.op));
                    check("alu_a", aluA, e.a);
                    check("alu_b", aluB, e.b);
                    check("rf_we", 32'(rfWe), 32'(e.we));
                    if (e.we) begin
                        check("rf_waddr", 32'(rfWaddr), 32'(e.waddr));
                        check("rf_wdata", rfWdata, e.wdata);
                    end
                    check("branch_valid", 32'(branchValid), 32'(e.bv));
                    if (e.bv) check("branch_taken", 32'(branchTaken), 32'(e.bt));
                    check("illegal", 32'(illegalOut), 32'(e.ill));
                    check("latency", 32'(cycleCnt - e.accept), 32'd3);
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input logic [31:0] iw, input logic [31:0] res, input logic cond);
        int   n = 0;
        expT  e;
        logic [4:0] rsIdx, rtIdx;
        @(negedge clk);
        while (!instrReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", 32'(instrReady), 32'd1);
        rsIdx        = iw[25:21];
        rtIdx        = iw[20:16];
        instr        = iw;
        aluResult    = res;
        aluCondition = cond;
        instrValid   = 1'b1;
        e = predict(iw, rfMem[rsIdx], rfMem[rtIdx], res, cond);
        e.accept = cycleCnt + 1;
        sb.push_back(e);
        issued++;
        if (e.ill) illegalIssued++;
        @(negedge clk);
        instrValid = 1'b0;
        waitDrain();
    endtask

    task automatic slowIssue(input logic [31:0] iw, input logic [31:0] res);
        int n = 0;
        int acc;
        @(negedge clk);
        check("slow_ready", 32'(slReady), 32'd1);
        instr     = iw;
        aluResult = res;
        slowValid = 1'b1;
        acc       = cycleCnt + 1;
        @(negedge clk);
        slowValid = 1'b0;
        while (!slDone && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("slow_done_seen", 32'(slDone), 32'd1);
        check("slow_latency", 32'(cycleCnt - acc), 32'd5);
        check("slow_we", 32'(slWe), 32'd1);
        check("slow_wdata", slWdata, res);
        check("slow_waddr", 32'(slWaddr), 32'(iw[20:16]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] iw;
        reset = 1'b1; instrValid = 1'b0; slowValid = 1'b0;
        instr = 32'h0; aluResult = 32'h0; aluCondition = 1'b0;
        for (int i = 0; i < 32; i++) rfMem[i] = 32'hA5A5_0000 | i;
        rfMem[0] = 32'h0; rfMem[1] = 32'd7; rfMem[2] = 32'd7; rfMem[3] = 32'd3;
        rfMem[5] = 32'h10; rfMem[9] = 32'd9; rfMem[10] = 32'd5;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_instr_ready", 32'(instrReady), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_we", 32'(rfWe), 32'd0);
        check("rst_alu_op", 32'(aluOp), 32'd0);
        check("rst_alu_a", aluA, 32'd0);
        check("rst_perf", perfRetired | 32'(perfIllegal), 32'd0);
        reset = 1'b0;

        issue({6'b001000, 5'd5, 5'd8, 16'hFFFF}, 32'h0000_000F, 1'b0);          // ADDI
        issue({6'b000101, 5'd1, 5'd2, 16'h0004}, 32'h0, 1'b1);                  // BNE equal
        issue({6'b000100, 5'd1, 5'd2, 16'h0004}, 32'h0, 1'b1);                  // BEQ equal
        issue({6'b000000, 5'd3, 5'd9, 5'd4, 5'd0, 6'b101010}, 32'h0, 1'b0);     // SLT
        issue({6'b000000, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100000}, 32'h1234, 1'b0);  // ADD to r0
        issue({6'b000000, 5'd1, 5'd10, 5'd6, 5'd0, 6'b001010}, 32'h55, 1'b0);   // MOVZ, rt != 0
        issue({6'b000000, 5'd1, 5'd10, 5'd6, 5'd0, 6'b001011}, 32'h66, 1'b0);   // MOVN, rt != 0
        issue({6'b000000, 5'd1, 5'd0, 5'd13, 5'd0, 6'b001010}, 32'h77, 1'b0);   // MOVZ, rt == 0
        issue({6'b001111, 5'd0, 5'd7, 16'h1234}, 32'h1234_0000, 1'b0);          // LUI
        issue({6'b011100, 5'd1, 5'd0, 5'd11, 5'd0, 6'b100000}, 32'd29, 1'b0);   // CLZ
        issue({6'b001100, 5'd3, 5'd14, 16'h8001}, 32'h1, 1'b0);                 // ANDI
        issue({6'b000111, 5'd9, 5'd0, 16'h0010}, 32'h0, 1'b1);                  // BGTZ
        issue({6'b110000, 26'h123_4567}, 32'hDEAD, 1'b1);                       // illegal opcode
        issue({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b001000}, 32'hBEEF, 1'b0);  // illegal funct
        for (int k = 0; k < 8; k++) begin
            iw = {6'b000000, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'd0, 3'b100, 3'($urandom_range(0, 7))};
            issue(iw, $urandom, 1'($urandom_range(0, 1)));
        end

`ifdef ALU_SEQ_PERF_EN
        check("perf_retired", perfRetired, 32'(issued));
        check("perf_illegal", 32'(perfIllegal), 32'(illegalIssued));
`else
        check("perf_retired_tied", perfRetired, 32'd0);
        check("perf_illegal_tied", 32'(perfIllegal), 32'd0);
`endif

        // Abort an ORI while its ALU inputs are being held.
        @(negedge clk);
        instr = {6'b001101, 5'd1, 5'd12, 16'h00F0};
        instrValid = 1'b1;
        @(negedge clk);
        instrValid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_instr_ready", 32'(instrReady), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rf_we", 32'(rfWe), 32'd0);
        check("abort_alu_op", 32'(aluOp), 32'd0);
        reset = 1'b0;
        issued = 0;
        illegalIssued = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("no_done_after_abort", 32'(done | rfWe), 32'd0);
        end

        issue({6'b001101, 5'd1, 5'd12, 16'h00F0}, 32'h0000_00F7, 1'b0);
        slowIssue({6'b001101, 5'd1, 5'd12, 16'h00F0}, 32'h0000_00F7);

`ifdef ALU_SEQ_PERF_EN
        check("perf_retired_after_reset", perfRetired, 32'(issued));
        check("perf_illegal_after_reset", 32'(perfIllegal), 32'(illegalIssued));
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
